fp_div: RTL and testbench

FP_DIV -- requirements
Module: fp_div

---
 rtl/fp_div.sv | 175 +++++++++++++++++
 tb/tb_fp_div.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/fp_div.sv
// Signed fixed-point divider: Dout = (Din0 << FRACTIONAL_BITS) / Din1, truncated toward zero,
// via sequential unsigned restoring division on magnitudes, with saturation and divide-by-zero flag.
module fp_div #(
    parameter int FRACTIONAL_BITS = 24,
    parameter int DATA_WIDTH      = 32,
    parameter int INTEGER_BITS    = DATA_WIDTH - FRACTIONAL_BITS
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] Din0,
    input  logic [DATA_WIDTH-1:0] Din1,
    output logic                  ready,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] Dout,
    output logic                  div_by_zero
);

    localparam int DW = DATA_WIDTH;
    localparam int FB = FRACTIONAL_BITS;
    // INTEGER_BITS is informational; it does not change the datapath.
    localparam int N  = DW + FB + (0 * INTEGER_BITS);
    localparam int CW = $clog2(N + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [DW-1:0] MAX_POS = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] MAX_NEG = {1'b1, {(DW-1){1'b0}}};
    localparam logic [N-1:0]  POS_LIM = {{(N-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic [N-1:0]  NEG_LIM = {{(N-DW){1'b0}}, 1'b1, {(DW-1){1'b0}}};

    logic [1:0]    state_r;
    logic [CW-1:0] cnt_r;
    logic [DW-1:0] a_r;
    logic [DW-1:0] b_r;
    logic [N-1:0]  dvd_r;
    logic [DW-1:0] dsr_r;
    logic [DW-1:0] rem_r;
    logic          ready_r;
    logic          done_r;
    logic [DW-1:0] dout_r;
    logic          dbz_r;

    logic [DW-1:0] mag_a_s;
    logic [DW-1:0] mag_b_s;
    logic [DW:0]   trial_s;
    logic [DW-1:0] diff_s;
    logic          fits_s;
    logic [DW-1:0] rem_next_s;
    logic [N-1:0]  q_final_s;
    logic          neg_s;
    logic          dz_s;
    logic [DW-1:0] res_s;

    // Operand magnitudes; unsigned DW bits hold 2^(DW-1) for the most-negative value.
    always_comb begin
        mag_a_s = a_r;
        mag_b_s = b_r;
        if (a_r[DW-1]) begin
            mag_a_s = {DW{1'b0}} - a_r;
        end else begin
            mag_a_s = a_r;
        end
        if (b_r[DW-1]) begin
            mag_b_s = {DW{1'b0}} - b_r;
        end else begin
            mag_b_s = b_r;
        end
    end

    // One restoring-division step; a fitting difference is below the divisor, so DW bits suffice.
    always_comb begin
        trial_s    = {rem_r, dvd_r[N-1]};
        fits_s     = (trial_s >= {1'b0, dsr_r});
        diff_s     = trial_s[DW-1:0] - dsr_r;
        rem_next_s = trial_s[DW-1:0];
        if (fits_s) begin
            rem_next_s = diff_s;
        end else begin
            rem_next_s = trial_s[DW-1:0];
        end
        q_final_s = {dvd_r[N-2:0], fits_s};
    end

    // Sign application, saturation and divide-by-zero substitution of the final quotient.
    always_comb begin
        neg_s = a_r[DW-1] ^ b_r[DW-1];
        dz_s  = (b_r == {DW{1'b0}});
        res_s = {DW{1'b0}};
        if (dz_s) begin
            res_s = a_r[DW-1] ? MAX_NEG : MAX_POS;
        end else if (neg_s) begin
            if (q_final_s > NEG_LIM) begin
                res_s = MAX_NEG;
            end else begin
                res_s = {DW{1'b0}} - q_final_s[DW-1:0];
            end
        end else begin
            if (q_final_s > POS_LIM) begin
                res_s = MAX_POS;
            end else begin
                res_s = q_final_s[DW-1:0];
            end
        end
    end

    // Control FSM and datapath: capture, one prep cycle, N division steps, one done cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            cnt_r   <= {CW{1'b0}};
            a_r     <= {DW{1'b0}};
            b_r     <= {DW{1'b0}};
            dvd_r   <= {N{1'b0}};
            dsr_r   <= {DW{1'b0}};
            rem_r   <= {DW{1'b0}};
            ready_r <= 1'b1;
            done_r  <= 1'b0;
            dout_r  <= {DW{1'b0}};
            dbz_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        a_r     <= Din0;
                        b_r     <= Din1;
                        cnt_r   <= {CW{1'b0}};
                        ready_r <= 1'b0;
                        state_r <= CALC;
                    end else begin
                        ready_r <= 1'b1;
                    end
                end
                CALC: begin
                    cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    if (cnt_r == {CW{1'b0}}) begin
                        dvd_r <= {mag_a_s, {FB{1'b0}}};
                        dsr_r <= mag_b_s;
                        rem_r <= {DW{1'b0}};
                    end else begin
                        rem_r <= rem_next_s;
                        dvd_r <= q_final_s;
                        if (cnt_r == CW'(N)) begin
                            dout_r  <= res_s;
                            dbz_r   <= dz_s;
                            done_r  <= 1'b1;
                            state_r <= DONE;
                        end else begin
                            state_r <= CALC;
                        end
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    ready_r <= 1'b1;
                    state_r <= IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    ready_r <= 1'b1;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign ready       = ready_r;
    assign done        = done_r;
    assign Dout        = dout_r;
    assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_fp_div.sv
// Directed self-checking bench for fp_div (Q8.24 defaults), hand-computed expectations.
module tb_fp_div;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [31:0] Din0;
    logic [31:0] Din1;
    logic        ready;
    logic        done;
    logic [31:0] Dout;
    logic        div_by_zero;

    int n_checks;
    int n_fail;

    fp_div dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .Din0        (Din0),
        .Din1        (Din1),
        .ready       (ready),
        .done        (done),
        .Dout        (Dout),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one request, measure edges from the accepting edge to done, check result.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_d, input logic exp_z);
        int k;
        int w;
        @(negedge clk);
        w = 0;
        while (ready !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk({tag, "_ready_idle"}, {31'd0, ready}, 32'd1);
        Din0  = a;
        Din1  = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        Din0  = 32'h1234_5678;
        Din1  = 32'h0000_0003;
        chk({tag, "_ready_busy"}, {31'd0, ready}, 32'd0);
        k = 0;
        while (done !== 1'b1 && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk({tag, "_latency"}, k, 32'd57);
        chk({tag, "_dout"}, Dout, exp_d);
        chk({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, exp_z});
        @(posedge clk);
        #1;
        chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        chk({tag, "_ready_after"}, {31'd0, ready}, 32'd1);
        chk({tag, "_dout_hold"}, Dout, exp_d);
    endtask

    initial begin
        int ndone;
        int first_lat;
        logic [31:0] first_dout;
        n_checks = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        start    = 1'b0;
        Din0     = 32'd0;
        Din1     = 32'd0;
        #23;
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_dout", Dout, 32'd0);
        chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        run_op("p3_over_2",   32'h0300_0000, 32'h0200_0000, 32'h0180_0000, 1'b0);
        run_op("m1_over_3",   32'hFF00_0000, 32'h0300_0000, 32'hFFAA_AAAB, 1'b0);
        run_op("sat_pos",     32'h6400_0000, 32'h0080_0000, 32'h7FFF_FFFF, 1'b0);
        run_op("dz_neg",      32'hFF00_0000, 32'h0000_0000, 32'h8000_0000, 1'b1);
        run_op("dz_zero",     32'h0000_0000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b1);
        run_op("min_over_1",  32'h8000_0000, 32'h0100_0000, 32'h8000_0000, 1'b0);
        run_op("min_over_m1", 32'h8000_0000, 32'hFF00_0000, 32'h7FFF_FFFF, 1'b0);
        run_op("zero_neg",    32'h0000_0000, 32'hFF00_0000, 32'h0000_0000, 1'b0);
        run_op("tiny_zero",   32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0000, 1'b0);
        run_op("lsb_over_m2", 32'h0000_0001, 32'hFFFF_FFFE, 32'hFF80_0000, 1'b0);
        run_op("seven_half",  32'h0000_0007, 32'h0000_0002, 32'h0380_0000, 1'b0);

        // Start held high with operands changing during CALC: one result from captured operands.
        @(negedge clk);
        Din0  = 32'h0300_0000;
        Din1  = 32'h0200_0000;
        start = 1'b1;
        @(posedge clk);
        #1;
        Din0       = 32'h0700_0000;
        Din1       = 32'hFD00_0000;
        ndone      = 0;
        first_lat  = 0;
        first_dout = 32'd0;
        for (int k = 1; k <= 120; k++) begin
            @(posedge clk);
            #1;
            if (k == 10) Din0 = 32'h0011_2233;
            if (k == 50) start = 1'b0;
            if (done === 1'b1) begin
                ndone++;
                if (ndone == 1) begin
                    first_lat  = k;
                    first_dout = Dout;
                end
            end
        end
        chk("hold_ndone", ndone, 32'd1);
        chk("hold_latency", first_lat, 32'd57);
        chk("hold_dout", first_dout, 32'h0180_0000);

        // Reset in the middle of CALC aborts with no done pulse.
        @(negedge clk);
        Din0  = 32'h0300_0000;
        Din1  = 32'h0200_0000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_ready", {31'd0, ready}, 32'd1);
        chk("mid_rst_dout", Dout, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        chk("mid_rst_dbz", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 80; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) ndone++;
        end
        chk("mid_rst_no_done", ndone, 32'd0);
        run_op("after_rst", 32'hFF00_0000, 32'h0300_0000, 32'hFFAA_AAAB, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
